// File: rtl/uart_periph_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit positions and the serialiser state encoding.
package uart_periph_pkg;

  localparam logic [11:0] UART_TXDATA  = 12'h000;
  localparam logic [11:0] UART_STATUS  = 12'h004;
  localparam logic [11:0] UART_BAUDDIV = 12'h008;

  localparam int STATUS_BUSY  = 0;
  localparam int STATUS_FULL  = 1;
  localparam int STATUS_EMPTY = 2;
  localparam int STATUS_LEVEL = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with head-of-queue read data and an occupancy counter.
// Depth must be a power of two so the pointers wrap naturally.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter on the core data port: bus decode,
// one-cycle response register, TX FIFO and the bit serialiser FSM.
module uart_tx_periph
  import uart_periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h9200_0000,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_d_addr_i,
  input  logic [31:0] mem_d_data_wr_i,
  input  logic        mem_d_rd_i,
  input  logic [3:0]  mem_d_wr_i,
  input  logic [10:0] mem_d_req_tag_i,
  output logic        mem_d_accept_o,
  output logic        mem_d_ack_o,
  output logic        mem_d_error_o,
  output logic [10:0] mem_d_resp_tag_o,
  output logic [31:0] mem_d_data_rd_o,
  output logic        uart_tx_o
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  // Handshake: a request is taken on a clock edge where accept is high; the core
  // holds it otherwise. Each taken request gets exactly one ack on the next cycle.
  logic [11:0]   offset;
  logic          win_hit;
  logic          is_wr;
  logic          hit;
  logic          wr_txdata;
  logic          wr_baud;
  logic          push;
  logic          pop;
  logic          bad_off;
  logic [31:0]   rd_word;
  logic [31:0]   status_word;
  logic [15:0]   baud_div;
  logic [15:0]   baud_next;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;
  logic [7:0]    fifo_dout;

  tx_state_e     state;
  logic [15:0]   cnt;
  logic [15:0]   div_q;
  logic [7:0]    shreg;
  logic [2:0]    bit_idx;
  logic          tx_q;
  logic          unused_bits;

  assign unused_bits = ^{mem_d_data_wr_i[31:16], mem_d_wr_i[3:2]};

  assign offset    = mem_d_addr_i[11:0];
  assign win_hit   = (mem_d_addr_i[31:12] == BASE_ADDR[31:12]);
  assign is_wr     = |mem_d_wr_i;
  assign hit       = (mem_d_rd_i | is_wr) & win_hit;
  assign wr_txdata = is_wr & (offset == UART_TXDATA);
  assign mem_d_accept_o = hit & ~(wr_txdata & fifo_full);
  assign push      = mem_d_accept_o & wr_txdata & mem_d_wr_i[0];
  assign wr_baud   = mem_d_accept_o & is_wr & (offset == UART_BAUDDIV);

  always_comb begin
    baud_next = baud_div;
    if (mem_d_wr_i[0]) baud_next[7:0]  = mem_d_data_wr_i[7:0];
    if (mem_d_wr_i[1]) baud_next[15:8] = mem_d_data_wr_i[15:8];
    if (baud_next == 16'd0) baud_next = 16'd1;
  end

  always_comb begin
    status_word = '0;
    status_word[STATUS_BUSY]  = (state != TX_IDLE);
    status_word[STATUS_FULL]  = fifo_full;
    status_word[STATUS_EMPTY] = fifo_empty;
    status_word[STATUS_LEVEL +: LW] = fifo_level;
  end

  always_comb begin
    rd_word = '0;
    bad_off = 1'b0;
    case (offset)
      UART_TXDATA:  rd_word = '0;
      UART_STATUS:  rd_word = status_word;
      UART_BAUDDIV: rd_word = {16'h0000, baud_div};
      default:      bad_off = 1'b1;
    endcase
    if (is_wr) rd_word = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_d_ack_o      <= 1'b0;
      mem_d_error_o    <= 1'b0;
      mem_d_resp_tag_o <= '0;
      mem_d_data_rd_o  <= '0;
      baud_div         <= DEFAULT_DIV;
    end else begin
      mem_d_ack_o <= mem_d_accept_o;
      if (mem_d_accept_o) begin
        mem_d_error_o    <= bad_off;
        mem_d_resp_tag_o <= mem_d_req_tag_i;
        mem_d_data_rd_o  <= bad_off ? 32'h0 : rd_word;
      end else begin
        mem_d_error_o    <= 1'b0;
        mem_d_data_rd_o  <= '0;
      end
      if (wr_baud) baud_div <= baud_next;
    end
  end

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (mem_d_data_wr_i[7:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // A frame is started from IDLE or straight out of the last STOP cycle, so
  // back-to-back bytes leave no idle gap on the line.
  assign pop = ~fifo_empty &
               ((state == TX_IDLE) | ((state == TX_STOP) & (cnt == 16'd0)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= TX_IDLE;
      tx_q    <= 1'b1;
      cnt     <= '0;
      div_q   <= 16'd1;
      shreg   <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        TX_IDLE: begin
          tx_q <= 1'b1;
          if (!fifo_empty) begin
            shreg <= fifo_dout;
            div_q <= baud_div;
            cnt   <= baud_div - 16'd1;
            tx_q  <= 1'b0;
            state <= TX_START;
          end
        end
        TX_START: begin
          if (cnt == 16'd0) begin
            tx_q    <= shreg[0];
            cnt     <= div_q - 16'd1;
            bit_idx <= '0;
            state   <= TX_DATA;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        TX_DATA: begin
          if (cnt == 16'd0) begin
            cnt <= div_q - 16'd1;
            if (bit_idx == 3'd7) begin
              tx_q  <= 1'b1;
              state <= TX_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= shreg >> 1;
              tx_q    <= shreg[1];
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        TX_STOP: begin
          if (cnt == 16'd0) begin
            if (!fifo_empty) begin
              shreg <= fifo_dout;
              div_q <= baud_div;
              cnt   <= baud_div - 16'd1;
              tx_q  <= 1'b0;
              state <= TX_START;
            end else begin
              state <= TX_IDLE;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: begin
          tx_q  <= 1'b1;
          state <= TX_IDLE;
        end
      endcase
    end
  end

  assign uart_tx_o = tx_q;

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed + randomized bench for uart_tx_periph: bus driver tasks, a line
// decoder feeding a byte scoreboard, and register checks against a small model.
module tb_uart_tx_periph;
  import uart_periph_pkg::*;

  localparam logic [31:0] BASE = 32'h9200_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_d_addr_i = '0;
  logic [31:0] mem_d_data_wr_i = '0;
  logic        mem_d_rd_i = 1'b0;
  logic [3:0]  mem_d_wr_i = '0;
  logic [10:0] mem_d_req_tag_i = '0;
  logic        mem_d_accept_o;
  logic        mem_d_ack_o;
  logic        mem_d_error_o;
  logic [10:0] mem_d_resp_tag_o;
  logic [31:0] mem_d_data_rd_o;
  logic        uart_tx;

  uart_tx_periph dut (
    .clk              (clk),
    .rst              (rst),
    .mem_d_addr_i     (mem_d_addr_i),
    .mem_d_data_wr_i  (mem_d_data_wr_i),
    .mem_d_rd_i       (mem_d_rd_i),
    .mem_d_wr_i       (mem_d_wr_i),
    .mem_d_req_tag_i  (mem_d_req_tag_i),
    .mem_d_accept_o   (mem_d_accept_o),
    .mem_d_ack_o      (mem_d_ack_o),
    .mem_d_error_o    (mem_d_error_o),
    .mem_d_resp_tag_o (mem_d_resp_tag_o),
    .mem_d_data_rd_o  (mem_d_data_rd_o),
    .uart_tx_o        (uart_tx)
  );

  // ---------------- clock / reset bookkeeping ----------------
  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_seen = 1'b1;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- model / scoreboard state ----------------
  logic [7:0] exp_q[$];
  int         start_q[$];
  int         gap_q[$];
  int         m_div = 868;
  logic       mon_busy = 1'b0;
  int         last_end = 0;
  int         acc_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- line decoder (monitor + scoreboard) ----------------
  initial begin : line_monitor
    int d;
    int bad;
    int start_cyc;
    logic [9:0] bits;
    logic aborted;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst_seen && uart_tx === 1'b0) begin
        mon_busy  = 1'b1;
        d         = m_div;
        start_cyc = cyc;
        bad       = 0;
        bits      = '0;
        aborted   = 1'b0;
        start_q.push_back(start_cyc);
        gap_q.push_back(start_cyc - last_end - 1);
        for (int i = 0; i < 10 * d; i++) begin
          if (i > 0) @(negedge clk);
          if (rst_seen) begin
            aborted = 1'b1;
            break;
          end
          if (i % d == 0) bits[i / d] = uart_tx;
          else if (uart_tx !== bits[i / d]) bad++;
        end
        if (!aborted) begin
          last_end = cyc;
          if (bits[0] !== 1'b0 || bits[9] !== 1'b1) bad++;
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", {24'h0, bits[8:1]}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("frame_byte", {24'h0, bits[8:1]}, {24'h0, e});
            chk("frame_shape", bad, 0);
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  // ---------------- driver tasks (start and end just after a negedge) ----------------
  task automatic do_access(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic rd, input logic [3:0] wr, input logic [10:0] tag,
                           input int budget, output logic acc, output logic [31:0] rdata,
                           output logic err, output int waits);
    acc = 1'b0; waits = 0; rdata = '0; err = 1'b0;
    mem_d_addr_i = addr; mem_d_data_wr_i = wdata; mem_d_rd_i = rd;
    mem_d_wr_i = wr; mem_d_req_tag_i = tag;
    while (!acc && waits < budget) begin
      #1;
      if (mem_d_accept_o === 1'b1) acc = 1'b1;
      @(negedge clk);
      if (!acc) waits++;
    end
    mem_d_rd_i = 1'b0;
    mem_d_wr_i = '0;
    if (acc) begin
      acc_cyc = cyc;
      chk("ack_next_cycle", {31'h0, mem_d_ack_o}, 32'h1);
      chk("resp_tag", {21'h0, mem_d_resp_tag_o}, {21'h0, tag});
      rdata = mem_d_data_rd_o;
      err   = mem_d_error_o;
      @(negedge clk);
      chk("single_ack", {31'h0, mem_d_ack_o}, 32'h0);
    end
  endtask

  task automatic reg_write(input logic [11:0] off, input logic [31:0] data,
                           input logic [3:0] wr, input int budget, output int waits);
    logic acc, err;
    logic [31:0] rd;
    logic [15:0] nd;
    do_access(BASE | {20'h0, off}, data, 1'b0, wr, 11'($urandom_range(0, 2047)),
              budget, acc, rd, err, waits);
    chk("wr_accept", {31'h0, acc}, 32'h1);
    if (acc) begin
      chk("wr_error", {31'h0, err}, 32'h0);
      if (off == UART_BAUDDIV) begin
        nd = m_div[15:0];
        if (wr[0]) nd[7:0]  = data[7:0];
        if (wr[1]) nd[15:8] = data[15:8];
        m_div = (nd == 16'd0) ? 1 : int'(nd);
      end
      if (off == UART_TXDATA && wr[0]) exp_q.push_back(data[7:0]);
    end
  endtask

  task automatic reg_read(input logic [11:0] off, input logic [10:0] tag,
                          output logic [31:0] data, output logic err);
    logic acc;
    int w;
    do_access(BASE | {20'h0, off}, 32'h0, 1'b1, 4'h0, tag, 20, acc, data, err, w);
    chk("rd_accept", {31'h0, acc}, 32'h1);
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || mon_busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("drain_in_time", {31'h0, k < budget}, 32'h1);
    @(negedge clk);
  endtask

  task automatic probe_miss(input logic [31:0] addr, input logic [3:0] wr, input int cycles);
    int bad = 0;
    mem_d_addr_i = addr; mem_d_rd_i = (wr == 4'h0); mem_d_wr_i = wr;
    mem_d_req_tag_i = 11'($urandom_range(0, 2047));
    repeat (cycles) begin
      #1;
      if (mem_d_accept_o !== 1'b0) bad++;
      @(negedge clk);
      if (mem_d_ack_o !== 1'b0) bad++;
    end
    mem_d_rd_i = 1'b0; mem_d_wr_i = '0;
    @(negedge clk);
    if (mem_d_ack_o !== 1'b0) bad++;
    chk("outside_window_ignored", bad, 0);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    logic [31:0] rd;
    logic err;
    int w, a, n_imm, bad, s0;
    logic [7:0] b1, b2;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'h0, mem_d_ack_o}, 32'h0);
    chk("rst_error", {31'h0, mem_d_error_o}, 32'h0);
    chk("rst_tag", {21'h0, mem_d_resp_tag_o}, 32'h0);
    chk("rst_data", mem_d_data_rd_o, 32'h0);
    chk("rst_tx", {31'h0, uart_tx}, 32'h1);
    rst = 1'b0;
    @(negedge clk);

    reg_read(UART_STATUS, 11'h001, rd, err);
    chk("status_reset", rd, 32'h0000_0004);
    reg_read(UART_BAUDDIV, 11'h002, rd, err);
    chk("bauddiv_reset", rd, 32'd868);

    // Undefined offset: error response, zero data, tag echoed
    reg_read(12'h00C, 11'h3A5, rd, err);
    chk("bad_off_err", {31'h0, err}, 32'h1);
    chk("bad_off_data", rd, 32'h0);

    // STATUS writes are ignored
    reg_write(UART_STATUS, 32'hFFFF_FFFF, 4'hF, 5, w);
    reg_read(UART_STATUS, 11'h003, rd, err);
    chk("status_after_write", rd, 32'h0000_0004);

    // Single frame, div 4
    reg_write(UART_BAUDDIV, 32'd4, 4'hF, 5, w);
    start_q.delete(); gap_q.delete();
    reg_write(UART_TXDATA, 32'h55, 4'h1, 5, w);
    a = acc_cyc;
    wait_drain(200);
    chk("start_latency", (start_q.size() > 0) ? start_q[0] - a : -1, 1);
    chk("idle_after_frame", {31'h0, uart_tx}, 32'h1);

    // "OK\n" back-to-back
    start_q.delete(); gap_q.delete();
    reg_write(UART_TXDATA, 32'h4F, 4'h1, 5, w);
    reg_write(UART_TXDATA, 32'h4B, 4'h1, 5, w);
    reg_write(UART_TXDATA, 32'h0A, 4'h1, 5, w);
    reg_read(UART_STATUS, 11'h004, rd, err);
    chk("status_mid_frame", rd, 32'h0000_0201);
    wait_drain(300);
    chk("frames_seen", start_q.size(), 3);
    chk("gap_1", (gap_q.size() > 1) ? gap_q[1] : -1, 0);
    chk("gap_2", (gap_q.size() > 2) ? gap_q[2] : -1, 0);

    // Random bytes through the FIFO at random small divisors
    repeat (3) begin
      reg_write(UART_BAUDDIV, 32'($urandom_range(1, 6)), 4'h3, 5, w);
      repeat (3) reg_write(UART_TXDATA, 32'($urandom_range(0, 255)), 4'h1, 5, w);
      wait_drain(400);
    end

    // BAUDDIV write of zero, byte enables
    reg_write(UART_BAUDDIV, 32'd0, 4'hF, 5, w);
    reg_read(UART_BAUDDIV, 11'h005, rd, err);
    chk("bauddiv_zero_is_one", rd, 32'd1);
    reg_write(UART_BAUDDIV, 32'h0000_0300, 4'h2, 5, w);
    reg_read(UART_BAUDDIV, 11'h006, rd, err);
    chk("bauddiv_byte_en", rd, 32'h0000_0301);

    // Divisor change mid-frame applies to the next frame only
    reg_write(UART_BAUDDIV, 32'd4, 4'hF, 5, w);
    start_q.delete(); gap_q.delete();
    b1 = 8'($urandom_range(0, 255));
    b2 = 8'($urandom_range(0, 255));
    reg_write(UART_TXDATA, {24'h0, b1}, 4'h1, 5, w);
    reg_write(UART_TXDATA, {24'h0, b2}, 4'h1, 5, w);
    repeat (10) @(negedge clk);
    reg_write(UART_BAUDDIV, 32'd8, 4'h3, 5, w);
    wait_drain(400);
    chk("frame_at_old_div", (start_q.size() > 1) ? start_q[1] - start_q[0] : -1, 40);

    // FIFO full back-pressure at div 100
    reg_write(UART_BAUDDIV, 32'd100, 4'hF, 5, w);
    n_imm = 0;
    for (int i = 0; i < 17; i++) begin
      reg_write(UART_TXDATA, 32'($urandom_range(0, 255)), 4'h1, 5, w);
      if (w == 0) n_imm++;
    end
    chk("writes_taken_immediately", n_imm, 17);
    reg_read(UART_STATUS, 11'h007, rd, err);
    chk("status_full", rd, 32'h0000_1003);
    reg_write(UART_TXDATA, 32'($urandom_range(0, 255)), 4'h1, 2000, w);
    chk("full_backpressure", {31'h0, w > 500}, 32'h1);
    wait_drain(20000);

    // Reset during DATA bit 3
    reg_write(UART_BAUDDIV, 32'd4, 4'hF, 5, w);
    start_q.delete();
    reg_write(UART_TXDATA, 32'($urandom_range(0, 127)), 4'h1, 5, w);
    a = acc_cyc;
    while (cyc < a + 18) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_frame_tx", {31'h0, uart_tx}, 32'h1);
    chk("rst_mid_frame_ack", {31'h0, mem_d_ack_o}, 32'h0);
    rst = 1'b0;
    exp_q.delete();
    m_div = 868;
    reg_read(UART_STATUS, 11'h008, rd, err);
    chk("status_after_rst", rd, 32'h0000_0004);
    s0 = start_q.size();
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) bad++;
    end
    chk("line_idle_after_rst", bad, 0);
    chk("no_new_frame", start_q.size(), s0);

    // Outside the window
    probe_miss(32'h8000_0000, 4'h0, 6);
    probe_miss(32'h9200_1000, 4'hF, 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
